// File: rtl/ir_capture_pio.sv
`default_nettype none
// ============================================================================
// ir_capture_pio : Avalon-MM input port with synchroniser, edge capture, irq
//                  and a channel-0 low-pulse width timer for IR demodulation.
// Optional glitch filter: define IR_CAPTURE_GLITCH_FILTER_EN.      Rev 1.0
// ============================================================================
module ir_capture_pio #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0,
  parameter int CNT_WIDTH   = 16,
  parameter int FILTER_LEN  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

  logic [WIDTH-1:0]     r_sync [SYNC_STAGES];
  logic [WIDTH-1:0]     w_sync;
  logic [WIDTH-1:0]     w_s;
  logic [WIDTH-1:0]     r_prev;
  logic [WIDTH-1:0]     w_rise;
  logic [WIDTH-1:0]     w_fall;
  logic [WIDTH-1:0]     w_sel;
  logic [WIDTH-1:0]     r_irqmask;
  logic [WIDTH-1:0]     r_edgecap;
  logic [WIDTH-1:0]     w_clr;
  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] r_width;
  logic [31:0]          r_readdata;
  logic [31:0]          w_rd;
  logic                 r_irq;
  logic                 w_wr;
  logic                 w_unused_wd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef IR_CAPTURE_GLITCH_FILTER_EN
  localparam int FCW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FCW-1:0] c_flt_last = FCW'(FILTER_LEN - 1);

  logic [WIDTH-1:0] r_filt;
  logic [FCW-1:0]   r_fcnt [WIDTH];

  // Count consecutive samples that disagree with the filtered value; any
  // agreeing sample restarts the run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_filt <= '0;
      for (int i = 0; i < WIDTH; i++) r_fcnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_sync[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == c_flt_last) begin
          r_filt[i] <= w_sync[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + FCW'(1);
        end
      end
    end
  end

  assign w_s = r_filt;
`else
  assign w_s = w_sync;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_prev <= '0;
    else       r_prev <= w_s;
  end

  assign w_rise = w_s & ~r_prev;
  assign w_fall = ~w_s & r_prev;

  generate
    if (EDGE_MODE == 0) begin : g_rise
      assign w_sel = w_rise;
    end else if (EDGE_MODE == 1) begin : g_fall
      assign w_sel = w_fall;
    end else begin : g_any
      assign w_sel = w_rise | w_fall;
    end
  endgenerate

  assign w_wr        = chipselect & ~write_n;
  assign w_clr       = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
  assign w_unused_wd = ^writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irqmask <= '0;
      r_edgecap <= '0;
      r_irq     <= 1'b0;
    end else begin
      if (w_wr && address == 2'd2) r_irqmask <= writedata[WIDTH-1:0];
      // A new edge beats a simultaneous clear of the same bit.
      r_edgecap <= (r_edgecap & ~w_clr) | w_sel;
      r_irq     <= |(r_edgecap & r_irqmask);
    end
  end

  // A zero counter means no fall has been seen since reset, so it stays
  // idle and a lone rise captures 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_width <= '0;
    end else begin
      if (w_fall[0]) begin
        r_count <= c_cnt_one;
      end else if (!w_s[0] && r_count != '0 && r_count != '1) begin
        r_count <= r_count + c_cnt_one;
      end
      if (w_rise[0]) r_width <= r_count;
    end
  end

  always_comb begin
    w_rd = '0;
    case (address)
      2'd0:    w_rd = 32'(w_s);
      2'd1:    w_rd = 32'(r_width);
      2'd2:    w_rd = 32'(r_irqmask);
      default: w_rd = 32'(r_edgecap);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_readdata <= '0;
    else       r_readdata <= w_rd;
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_ir_capture_pio.sv
`default_nettype none
// ============================================================================
// tb_ir_capture_pio : directed and randomized bench for ir_capture_pio.
// Rev 1.0
// ============================================================================
module tb_ir_capture_pio;

  localparam int W    = 4;
  localparam int SYNC = 2;
  localparam int CW   = 16;
  localparam int FL   = 4;
`ifdef IR_CAPTURE_GLITCH_FILTER_EN
  localparam int FLAT = FL;
`else
  localparam int FLAT = 0;
`endif
  localparam int LAT  = SYNC + FLAT;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   readdata;
  logic          irq;

  int            checks = 0;
  int            errors = 0;

  // Reference model state
  logic [W-1:0]  cur_in;
  logic [W-1:0]  exp_ec;
  int            exp_width;
  int            low_len;
  bit            seen_fall;

  ir_capture_pio #(
    .WIDTH(W), .SYNC_STAGES(SYNC), .EDGE_MODE(0), .CNT_WIDTH(CW), .FILTER_LEN(FL)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (cur_in[0] == 1'b0) low_len++;
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  // Apply a new input value and update the behavioural expectations.
  task automatic set_in(input logic [W-1:0] v);
    exp_ec = exp_ec | (v & ~cur_in);
    if (cur_in[0] && !v[0]) begin
      low_len   = 0;
      seen_fall = 1'b1;
    end
    if (!cur_in[0] && v[0])
      exp_width = seen_fall ? ((low_len > CMAX) ? CMAX : low_len) : 0;
    cur_in  = v;
    in_port = v;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    tick();
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    cur_in = 4'hA; in_port = 4'hA;
    settle(3);
    checks++;
    if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata actual=%h required=%h", readdata, 32'h0); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq actual=%b required=0", irq); end
    reset = 1'b0;
    exp_ec = cur_in; exp_width = 0; low_len = 0; seen_fall = 1'b0;
    settle(LAT + 2);
    checks++;
    if (readdata !== 32'h0000000A) begin errors++; $display("FAIL reset_data actual=%h required=%h", readdata, 32'hA); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq_masked actual=%b required=0", irq); end
    bus_read(2'd1, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_width actual=%0d required=0", rd); end
    bus_read(2'd2, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_mask actual=%h required=0", rd); end
    bus_read(2'd3, rd);
    checks++;
    if (rd !== 32'h0000000A) begin errors++; $display("FAIL reset_edgecap actual=%h required=%h", rd, 32'hA); end
  endtask

  task automatic test_edge_irq();
    logic [31:0] rd;
    logic [31:0] want;
    set_in(4'h0);
    settle(LAT + 6);
    bus_write(2'd2, 32'h1);
    bus_write(2'd3, 32'hF);
    exp_ec = '0;
    address = 2'd3;
    tick();
    checks++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      errors++; $display("FAIL edge_cleared actual=%h/%b required=0/0", readdata, irq);
    end
    set_in(4'h1);
    for (int k = 1; k <= LAT + 2; k++) begin
      tick();
      want = (k >= LAT + 2) ? 32'h1 : 32'h0;
      checks++;
      if (readdata !== want || irq !== want[0]) begin
        errors++; $display("FAIL edge_timing_t%0d actual=%h/%b required=%h/%b", k, readdata, irq, want, want[0]);
      end
    end
    bus_write(2'd3, 32'h1);
    exp_ec = '0;
    tick();
    checks++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      errors++; $display("FAIL edge_w1c actual=%h/%b required=0/0", readdata, irq);
    end
    bus_read(2'd1, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL rise_without_fall_width actual=%0d required=0", rd); end
  endtask

  task automatic test_same_cycle();
    logic [31:0] rd;
    set_in(4'h0);
    settle(8);
    set_in(4'h1);
    settle(LAT);
    bus_write(2'd3, 32'h1);
    settle(3);
    bus_read(2'd3, rd);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL same_cycle_edge_wins actual=%h required=%h", rd, 32'h1); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL same_cycle_irq actual=%b required=1", irq); end
    bus_read(2'd1, rd);
    checks++;
    if (rd !== 32'd8) begin errors++; $display("FAIL width_8 actual=%0d required=8", rd); end
  endtask

  task automatic test_width();
    logic [31:0] rd;
    set_in(4'h0);
    settle(100);
    set_in(4'h1);
    settle(LAT + 4);
    bus_read(2'd1, rd);
    checks++;
    if (rd !== 32'd100) begin errors++; $display("FAIL width_100 actual=%0d required=100", rd); end
    set_in(4'h0);
    settle(70000);
    set_in(4'h1);
    settle(LAT + 4);
    bus_read(2'd1, rd);
    checks++;
    if (rd !== 32'd65535) begin errors++; $display("FAIL width_saturate actual=%0d required=65535", rd); end
  endtask

  task automatic test_glitch();
    logic [31:0] rd;
    bus_write(2'd3, 32'hF);
    exp_ec = '0;
    set_in(4'h0);
    settle(3);
    set_in(4'h1);
    settle(12);
    bus_read(2'd0, rd);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL glitch_data actual=%h required=%h", rd, 32'h1); end
    bus_read(2'd3, rd);
    checks++;
`ifdef IR_CAPTURE_GLITCH_FILTER_EN
    if (rd !== 32'h0) begin errors++; $display("FAIL glitch_filtered actual=%h required=%h", rd, 32'h0); end
`else
    if (rd !== 32'h1) begin errors++; $display("FAIL glitch_captured actual=%h required=%h", rd, 32'h1); end
`endif
    bus_write(2'd3, 32'hF);
    set_in(4'h0);
    settle(4);
    set_in(4'h1);
    settle(12);
    exp_ec = 4'h1;
    bus_read(2'd3, rd);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL pulse4_edge actual=%h required=%h", rd, 32'h1); end
    bus_read(2'd1, rd);
    checks++;
    if (rd !== 32'd4) begin errors++; $display("FAIL pulse4_width actual=%0d required=4", rd); end
  endtask

  task automatic test_random();
    logic [31:0]  rd;
    logic [W-1:0] v, m, c;
    for (int it = 0; it < 6; it++) begin
      bus_write(2'd3, 32'hF);
      exp_ec = '0;
      for (int sgm = 0; sgm < 6; sgm++) begin
        v = W'($urandom_range(0, 15));
        set_in(v);
        settle($urandom_range(6, 20));
      end
      settle(8);
      bus_read(2'd0, rd);
      checks++;
      if (rd !== 32'(cur_in)) begin errors++; $display("FAIL rand%0d_data actual=%h required=%h", it, rd, cur_in); end
      bus_read(2'd3, rd);
      checks++;
      if (rd !== 32'(exp_ec)) begin errors++; $display("FAIL rand%0d_edgecap actual=%h required=%h", it, rd, exp_ec); end
      bus_read(2'd1, rd);
      checks++;
      if (rd !== 32'(exp_width)) begin errors++; $display("FAIL rand%0d_width actual=%0d required=%0d", it, rd, exp_width); end
      m = W'($urandom_range(0, 15));
      bus_write(2'd2, 32'(m));
      settle(2);
      checks++;
      if (irq !== |(exp_ec & m)) begin errors++; $display("FAIL rand%0d_irq actual=%b required=%b", it, irq, |(exp_ec & m)); end
      bus_read(2'd2, rd);
      checks++;
      if (rd !== 32'(m)) begin errors++; $display("FAIL rand%0d_mask actual=%h required=%h", it, rd, m); end
      c = W'($urandom_range(0, 15));
      bus_write(2'd3, {$urandom_range(0, 255), 24'h0} | 32'(c));
      exp_ec = exp_ec & ~c;
      bus_read(2'd3, rd);
      checks++;
      if (rd !== 32'(exp_ec)) begin errors++; $display("FAIL rand%0d_w1c actual=%h required=%h", it, rd, exp_ec); end
    end
  endtask

  task automatic test_reset_mid_pulse();
    logic [31:0] rd;
    set_in(4'h1);
    settle(8);
    set_in(4'h0);
    settle(30);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_ec = '0; exp_width = 0; low_len = 0; seen_fall = 1'b0;
    settle(LAT + 4);
    bus_read(2'd1, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL midpulse_width_cleared actual=%0d required=0", rd); end
    set_in(4'h1);
    settle(LAT + 4);
    bus_read(2'd1, rd);
    checks++;
    if (rd !== 32'(exp_width)) begin errors++; $display("FAIL midpulse_discarded actual=%0d required=%0d", rd, exp_width); end
    bus_read(2'd3, rd);
    checks++;
    if (rd !== 32'(exp_ec)) begin errors++; $display("FAIL midpulse_edgecap actual=%h required=%h", rd, exp_ec); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL midpulse_irq actual=%b required=0", irq); end
  endtask

  initial begin
    cur_in = '0; exp_ec = '0; exp_width = 0; low_len = 0; seen_fall = 1'b0;
    test_reset();
    test_edge_irq();
    test_same_cycle();
    test_width();
    test_glitch();
    test_random();
    test_reset_mid_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
